// File: rtl/abro_monitor.sv
// Cycle-accurate ABRO reference model plus mismatch/error bookkeeping for an observed ABRO instance.
// Define ABRO_MON_STATE_CHECK_EN to also compare the observed state vector, not only O.
module abro_monitor #(
    parameter int         CNT_W   = 16,
    parameter logic [1:0] ST_IDLE = 2'd0,
    parameter logic [1:0] ST_GOTA = 2'd1,
    parameter logic [1:0] ST_GOTB = 2'd2,
    parameter logic [1:0] ST_DONE = 2'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mon_en,
    input  logic             dut_rst,
    input  logic             A,
    input  logic             B,
    input  logic             O,
    input  logic [1:0]       state,
    output logic [1:0]       exp_state,
    output logic             exp_O,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] first_err_cyc
);

    typedef enum logic [1:0] {
        M_IDLE = ST_IDLE,
        M_GOTA = ST_GOTA,
        M_GOTB = ST_GOTB,
        M_DONE = ST_DONE
    } model_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    model_state_t     st_q, st_d;
    logic             mismatch_q, mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    logic [CNT_W-1:0] first_err_cyc_q, first_err_cyc_d;
    logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
    logic             exp_o_w;
    logic             err_now;

    assign exp_o_w = (st_q == M_DONE);

    // Reference model: runs regardless of mon_en so re-enabling resumes in lock-step.
    always_comb begin
        st_d = st_q;
        if (dut_rst) begin
            st_d = M_IDLE;
        end else begin
            case (st_q)
                M_IDLE: begin
                    if (A && B)  st_d = M_DONE;
                    else if (A)  st_d = M_GOTA;
                    else if (B)  st_d = M_GOTB;
                end
                M_GOTA:  if (B) st_d = M_DONE;
                M_GOTB:  if (A) st_d = M_DONE;
                M_DONE:  st_d = M_DONE;
                default: st_d = M_IDLE;
            endcase
        end
    end

`ifdef ABRO_MON_STATE_CHECK_EN
    assign err_now = (O != exp_o_w) || (state != st_q);
`else
    logic state_unused;
    assign state_unused = ^state;
    assign err_now = (O != exp_o_w);
`endif

    always_comb begin
        mismatch_d      = mon_en && !dut_rst && err_now;
        err_sticky_d    = err_sticky_q || mismatch_d;
        err_count_d     = err_count_q;
        first_err_cyc_d = first_err_cyc_q;
        cyc_count_d     = cyc_count_q;
        done_count_d    = done_count_q;
        if (mismatch_d && (err_count_q != CNT_MAX))
            err_count_d = err_count_q + CNT_W'(1);
        // Capture the cycle index of the cycle being judged, i.e. before this edge's increment.
        if (mismatch_d && !err_sticky_q)
            first_err_cyc_d = cyc_count_q;
        if (mon_en && (cyc_count_q != CNT_MAX))
            cyc_count_d = cyc_count_q + CNT_W'(1);
        if (mon_en && (st_q != M_DONE) && (st_d == M_DONE) && (done_count_q != CNT_MAX))
            done_count_d = done_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q            <= M_IDLE;
            mismatch_q      <= 1'b0;
            err_sticky_q    <= 1'b0;
            err_count_q     <= '0;
            done_count_q    <= '0;
            first_err_cyc_q <= '0;
            cyc_count_q     <= '0;
        end else begin
            st_q            <= st_d;
            mismatch_q      <= mismatch_d;
            err_sticky_q    <= err_sticky_d;
            err_count_q     <= err_count_d;
            done_count_q    <= done_count_d;
            first_err_cyc_q <= first_err_cyc_d;
            cyc_count_q     <= cyc_count_d;
        end
    end

    assign exp_state     = st_q;
    assign exp_O         = exp_o_w;
    assign mismatch      = mismatch_q;
    assign err_sticky    = err_sticky_q;
    assign err_count     = err_count_q;
    assign done_count    = done_count_q;
    assign first_err_cyc = first_err_cyc_q;

endmodule
